saturn_bus_prog_reader: RTL and testbench

- Consumer end of the 32-entry bus program ring that the control unit fills.
- Compares its read pointer with the writer's next-write pointer and pops one 5-bit entry per bus slot: bit4=1 is a command, bit4=0 is a data nibble.
- Replays each entry onto the nibble bus and tracks the PC loaded by LOAD_PC sequences. After a LOAD_PC it auto-increments that PC on idle read slots.
- Sits between the control unit and the external Saturn bus; also drives i_bus_busy back to the control unit.

---
 rtl/saturn_bus_prog_reader_if.sv | 43 ++++
 rtl/saturn_bus_prog_reader.sv | 155 +++++++++++++++
 tb/tb_saturn_bus_prog_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/saturn_bus_prog_reader_if.sv
// Bus-program ring read port plus nibble-bus outputs of the program reader.
// master = reader side, slave = control unit / external bus side.
interface saturn_bus_prog_reader_if #(
    parameter int PC_NIBBLES = 5,
    parameter int PROG_AW    = 5
);
    logic [PROG_AW-1:0]      i_program_address;
    logic [4:0]              i_program_data;
    logic [PROG_AW-1:0]      o_program_address;
    logic                    o_bus_strobe;
    logic                    o_bus_cmd_data;
    logic [3:0]              o_bus_nibble;
    logic                    o_bus_busy;
    logic [4*PC_NIBBLES-1:0] o_loaded_pc;
    logic                    o_pc_valid;
    logic                    o_error;

    modport master (
        input  i_program_address,
        input  i_program_data,
        output o_program_address,
        output o_bus_strobe,
        output o_bus_cmd_data,
        output o_bus_nibble,
        output o_bus_busy,
        output o_loaded_pc,
        output o_pc_valid,
        output o_error
    );

    modport slave (
        output i_program_address,
        output i_program_data,
        input  o_program_address,
        input  o_bus_strobe,
        input  o_bus_cmd_data,
        input  o_bus_nibble,
        input  o_bus_busy,
        input  o_loaded_pc,
        input  o_pc_valid,
        input  o_error
    );
endinterface

// File: rtl/saturn_bus_prog_reader.sv
// Consumer of the bus program ring: replays entries onto the nibble bus,
// assembles the LOAD_PC operand and auto-increments that PC on idle read slots.
module saturn_bus_prog_reader #(
    parameter int PC_NIBBLES = 5,
    parameter int PROG_AW    = 5
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_clk_en,
    input  logic [3:0]                       i_phases,
    saturn_bus_prog_reader_if.master         bus
);

    localparam int PCW = 4 * PC_NIBBLES;
    localparam int CW  = (PC_NIBBLES > 1) ? $clog2(PC_NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PC_NIBBLES - 1);
    localparam logic [3:0] BUSCMD_LOAD_PC = 4'h4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ADDR = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PROG_AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               strobe_q, strobe_d;
    logic               cmd_data_q, cmd_data_d;
    logic [3:0]         nibble_q, nibble_d;
    logic               busy_q, busy_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic               error_q, error_d;

    logic               slot;
    logic               empty;
    logic [4:0]         entry;
    logic               unused_phases;

    assign unused_phases = ^i_phases[3:1];
    assign slot  = i_clk_en && i_phases[0];
    assign empty = (ptr_q == bus.i_program_address);
    assign entry = bus.i_program_data;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        cmd_data_d = cmd_data_q;
        nibble_d   = nibble_q;
        busy_d     = busy_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        error_d    = error_q;
        // Strobe is a pulse, but with the clock enable low nothing may change.
        strobe_d   = i_clk_en ? 1'b0 : strobe_q;

        if (slot) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        ptr_d = ptr_q + 1'b1;
                        if (entry[4]) begin
                            strobe_d   = 1'b1;
                            cmd_data_d = 1'b1;
                            nibble_d   = entry[3:0];
                            busy_d     = 1'b1;
                            if (entry[3:0] == BUSCMD_LOAD_PC) begin
                                pc_valid_d = 1'b0;
                                cnt_d      = '0;
                                state_d    = ST_ADDR;
                            end
                        end else begin
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        busy_d = 1'b0;
                        if (pc_valid_q) begin
                            strobe_d   = 1'b1;
                            cmd_data_d = 1'b0;
                            nibble_d   = pc_q[3:0];
                            pc_d       = pc_q + 1'b1;
                        end
                    end
                end

                ST_ADDR: begin
                    if (!empty) begin
                        // A command here is left in the ring so IDLE replays it next slot.
                        if (entry[4]) begin
                            error_d    = 1'b1;
                            pc_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            cnt_d      = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            strobe_d   = 1'b1;
                            cmd_data_d = 1'b0;
                            nibble_d   = entry[3:0];
                            ptr_d      = ptr_q + 1'b1;
                            pc_d[{cnt_q, 2'b00} +: 4] = entry[3:0];
                            if (cnt_q == CNT_LAST) begin
                                pc_valid_d = 1'b1;
                                busy_d     = 1'b0;
                                cnt_d      = '0;
                                state_d    = ST_IDLE;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            cmd_data_q <= 1'b0;
            nibble_q   <= 4'h0;
            busy_q     <= 1'b0;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            strobe_q   <= strobe_d;
            cmd_data_q <= cmd_data_d;
            nibble_q   <= nibble_d;
            busy_q     <= busy_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            error_q    <= error_d;
        end
    end

    assign bus.o_program_address = ptr_q;
    assign bus.o_bus_strobe      = strobe_q;
    assign bus.o_bus_cmd_data    = cmd_data_q;
    assign bus.o_bus_nibble      = nibble_q;
    assign bus.o_bus_busy        = busy_q;
    assign bus.o_loaded_pc       = pc_q;
    assign bus.o_pc_valid        = pc_valid_q;
    assign bus.o_error           = error_q;

endmodule

// File: tb/tb_saturn_bus_prog_reader.sv
// Directed bench for saturn_bus_prog_reader: a behavioural ring writer feeds
// entries, one bus slot is four clocks, expected values are hand-computed.
module tb_saturn_bus_prog_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clk_en = 1'b1;
    logic [3:0] phases = 4'b1000;

    logic [4:0] ring [0:31];
    logic [4:0] wr_ptr = 5'd0;

    logic       s_strobe;
    logic       s_cmd;
    logic [3:0] s_nib;

    int total = 0;
    int bad   = 0;

    saturn_bus_prog_reader_if #(.PC_NIBBLES(5), .PROG_AW(5)) bus_if ();

    assign bus_if.i_program_address = wr_ptr;
    assign bus_if.i_program_data    = ring[bus_if.o_program_address];

    saturn_bus_prog_reader #(.PC_NIBBLES(5), .PROG_AW(5)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_clk_en  (clk_en),
        .i_phases  (phases),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushEntry(input logic [4:0] e);
        ring[wr_ptr] = e;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    // One bus slot; bus outputs are captured just after the slot edge.
    task automatic applyStimulus();
        @(negedge clk); phases = 4'b0001;
        @(negedge clk);
        s_strobe = bus_if.o_bus_strobe;
        s_cmd    = bus_if.o_bus_cmd_data;
        s_nib    = bus_if.o_bus_nibble;
        phases   = 4'b0010;
        @(negedge clk); phases = 4'b0100;
        @(negedge clk); phases = 4'b1000;
    endtask

    task automatic checkSlot(input string tag, input logic strb, input logic cmd, input logic [3:0] nib);
        checkOutput({tag, "_strobe"}, 32'(s_strobe), 32'(strb));
        if (strb) begin
            checkOutput({tag, "_cmd"}, 32'(s_cmd), 32'(cmd));
            checkOutput({tag, "_nib"}, 32'(s_nib), 32'(nib));
        end
    endtask

    logic [3:0] exp_nib  [0:5] = '{4'h4, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    logic       exp_cmd  [0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_busy [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 32; i++) ring[i] = 5'h00;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_addr",  32'(bus_if.o_program_address), 32'd0);
        checkOutput("rst_strobe", 32'(bus_if.o_bus_strobe), 32'd0);
        checkOutput("rst_busy",  32'(bus_if.o_bus_busy), 32'd0);
        checkOutput("rst_pc",    32'(bus_if.o_loaded_pc), 32'd0);
        checkOutput("rst_valid", 32'(bus_if.o_pc_valid), 32'd0);
        checkOutput("rst_err",   32'(bus_if.o_error), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // LOAD_PC 0x12345
        pushEntry(5'h14);
        pushEntry(5'h05); pushEntry(5'h04); pushEntry(5'h03); pushEntry(5'h02); pushEntry(5'h01);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkSlot($sformatf("ld%0d", i), 1'b1, exp_cmd[i], exp_nib[i]);
            checkOutput($sformatf("ld%0d_busy", i), 32'(bus_if.o_bus_busy), 32'(exp_busy[i]));
        end
        checkOutput("ld_strobe_low", 32'(bus_if.o_bus_strobe), 32'd0);
        checkOutput("ld_pc",    32'(bus_if.o_loaded_pc), 32'h12345);
        checkOutput("ld_valid", 32'(bus_if.o_pc_valid), 32'd1);
        checkOutput("ld_addr",  32'(bus_if.o_program_address), 32'd6);

        // Auto-increment read slots
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkSlot($sformatf("rd%0d", i), 1'b1, 1'b0, 4'(5 + i));
            checkOutput($sformatf("rd%0d_pc", i), 32'(bus_if.o_loaded_pc), 32'h12346 + 32'(i));
        end

        // Walk pointer to 30 with plain commands
        for (int i = 0; i < 24; i++) pushEntry(5'h1F);
        for (int i = 0; i < 24; i++) applyStimulus();
        checkSlot("walk", 1'b1, 1'b1, 4'hF);
        checkOutput("walk_addr", 32'(bus_if.o_program_address), 32'd30);
        checkOutput("walk_busy", 32'(bus_if.o_bus_busy), 32'd1);
        checkOutput("walk_pc",   32'(bus_if.o_loaded_pc), 32'h12348);
        applyStimulus();
        checkSlot("walk_rd", 1'b1, 1'b0, 4'h8);
        checkOutput("walk_rd_busy", 32'(bus_if.o_bus_busy), 32'd0);

        // LOAD_PC 0xFFFFF across the wrap
        pushEntry(5'h14);
        for (int i = 0; i < 5; i++) pushEntry(5'h0F);
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("wrap_pc",    32'(bus_if.o_loaded_pc), 32'hFFFFF);
        checkOutput("wrap_valid", 32'(bus_if.o_pc_valid), 32'd1);
        checkOutput("wrap_addr",  32'(bus_if.o_program_address), 32'd4);
        applyStimulus();
        checkSlot("wrap_rd0", 1'b1, 1'b0, 4'hF);
        checkOutput("wrap_rd0_pc", 32'(bus_if.o_loaded_pc), 32'h00000);
        applyStimulus();
        checkSlot("wrap_rd1", 1'b1, 1'b0, 4'h0);
        checkOutput("wrap_rd1_pc", 32'(bus_if.o_loaded_pc), 32'h00001);

        // Orphan data in IDLE
        pushEntry(5'h07);
        applyStimulus();
        checkSlot("orph", 1'b0, 1'b0, 4'h0);
        checkOutput("orph_err",  32'(bus_if.o_error), 32'd1);
        checkOutput("orph_addr", 32'(bus_if.o_program_address), 32'd5);
        checkOutput("orph_pc",   32'(bus_if.o_loaded_pc), 32'h00001);

        // Truncated LOAD_PC interrupted by a new LOAD_PC
        pushEntry(5'h14); pushEntry(5'h0A); pushEntry(5'h0B); pushEntry(5'h0C); pushEntry(5'h14);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("trunc_addr", 32'(bus_if.o_program_address), 32'd9);
        applyStimulus();
        checkSlot("abort", 1'b0, 1'b0, 4'h0);
        checkOutput("abort_err",   32'(bus_if.o_error), 32'd1);
        checkOutput("abort_valid", 32'(bus_if.o_pc_valid), 32'd0);
        checkOutput("abort_addr",  32'(bus_if.o_program_address), 32'd9);
        checkOutput("abort_pc",    32'(bus_if.o_loaded_pc), 32'h00CBA);
        applyStimulus();
        checkSlot("relo", 1'b1, 1'b1, 4'h4);
        checkOutput("relo_addr", 32'(bus_if.o_program_address), 32'd10);
        checkOutput("relo_busy", 32'(bus_if.o_bus_busy), 32'd1);

        // Asynchronous reset mid-operand
        pushEntry(5'h01); pushEntry(5'h02);
        applyStimulus();
        applyStimulus();
        checkSlot("mid", 1'b1, 1'b0, 4'h2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        wr_ptr = 5'd0;
        #1;
        checkOutput("arst_addr", 32'(bus_if.o_program_address), 32'd0);
        checkOutput("arst_nib",  32'(bus_if.o_bus_nibble), 32'd0);
        checkOutput("arst_busy", 32'(bus_if.o_bus_busy), 32'd0);
        checkOutput("arst_pc",   32'(bus_if.o_loaded_pc), 32'd0);
        checkOutput("arst_err",  32'(bus_if.o_error), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkSlot($sformatf("idle%0d", i), 1'b0, 1'b0, 4'h0);
        end
        checkOutput("idle_addr", 32'(bus_if.o_program_address), 32'd0);

        // Clock enable held low with entries waiting
        pushEntry(5'h12); pushEntry(5'h14);
        @(negedge clk); clk_en = 1'b0; phases = 4'b0001;
        for (int i = 0; i < 10; i++) @(negedge clk);
        checkOutput("cen_addr",   32'(bus_if.o_program_address), 32'd0);
        checkOutput("cen_strobe", 32'(bus_if.o_bus_strobe), 32'd0);
        checkOutput("cen_busy",   32'(bus_if.o_bus_busy), 32'd0);
        checkOutput("cen_nib",    32'(bus_if.o_bus_nibble), 32'd0);
        phases = 4'b1000; clk_en = 1'b1;
        applyStimulus();
        checkSlot("cen_r0", 1'b1, 1'b1, 4'h2);
        checkOutput("cen_r0_addr", 32'(bus_if.o_program_address), 32'd1);
        applyStimulus();
        checkSlot("cen_r1", 1'b1, 1'b1, 4'h4);
        checkOutput("cen_r1_addr", 32'(bus_if.o_program_address), 32'd2);
        checkOutput("cen_r1_busy", 32'(bus_if.o_bus_busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
